// File: rtl/ppg_dual_filter_sched_if.sv
// Sample/result bundle between the MAX30102 driver, the shared PPG filter and
// the SpO2/heart-rate calculators.
interface ppg_dual_filter_sched_if #(
  parameter int DATA_WIDTH = 18
);
  logic                  i_red_valid;
  logic [DATA_WIDTH-1:0] i_red_data;
  logic                  i_ir_valid;
  logic [DATA_WIDTH-1:0] i_ir_data;
  logic                  i_ovf_clr;
  logic                  o_valid;
  logic                  o_chan;
  logic [DATA_WIDTH:0]   o_ac;
  logic [DATA_WIDTH-1:0] o_dc;
  logic                  o_ovf_red;
  logic                  o_ovf_ir;
  logic                  o_busy;

  modport master (
    output i_red_valid, i_red_data, i_ir_valid, i_ir_data, i_ovf_clr,
    input  o_valid, o_chan, o_ac, o_dc, o_ovf_red, o_ovf_ir, o_busy
  );

  modport slave (
    input  i_red_valid, i_red_data, i_ir_valid, i_ir_data, i_ovf_clr,
    output o_valid, o_chan, o_ac, o_dc, o_ovf_red, o_ovf_ir, o_busy
  );
endinterface

// File: rtl/ppg_dual_filter_sched.sv
// Shared 4-tap moving average + IIR DC tracker, round-robin between RED and IR.
// Define PPG_SEED_DC_EN to seed each channel's context from its first sample.
module ppg_dual_filter_sched #(
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int DC_SHIFT   = 5
) (
  input logic clk,
  input logic rst,
  ppg_dual_filter_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = DATA_WIDTH + 9;
  localparam int SW = DATA_WIDTH + 2;

  // state | meaning: IDLE wait for data | FETCH pop + load context | CALC moving average | WB IIR, write back, emit
  typedef enum logic [1:0] {IDLE, FETCH, CALC, WB} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr [2];
  logic [PW-1:0]         rd_ptr [2];
  logic [PW:0]           count [2];
  logic [DATA_WIDTH-1:0] din [2];
  logic [1:0]            push, pop, full, nonempty, accept, drop;

  logic [DATA_WIDTH-1:0] h0_bank [2];
  logic [DATA_WIDTH-1:0] h1_bank [2];
  logic [DATA_WIDTH-1:0] h2_bank [2];
  logic [AW-1:0]         acc_bank [2];

  logic                  grant, last, last_eff, pick, any;
  logic [DATA_WIDTH-1:0] x, h0, h1, h2, lpf;
  logic [AW-1:0]         acc, acc_nx;
  logic [SW-1:0]         sum;
  logic [DATA_WIDTH-1:0] lpf_eff, dc_nx, h1_nx, h2_nx;
  logic [DATA_WIDTH:0]   ac_nx;
`ifdef PPG_SEED_DC_EN
  logic [1:0]            seeded;
`endif

  always_comb begin
    din[0] = bus.i_red_data;
    din[1] = bus.i_ir_data;
    push   = {bus.i_ir_valid, bus.i_red_valid};
    for (int c = 0; c < 2; c++) begin
      nonempty[c] = (count[c] != '0);
      full[c]     = (count[c] == (PW+1)'(FIFO_DEPTH));
      pop[c]      = (state == FETCH) && (grant == c[0]);
      accept[c]   = push[c] && (!full[c] || pop[c]);
      drop[c]     = push[c] && full[c] && !pop[c];
    end
  end

  // In WB the channel being retired counts as last served for the next grant.
  always_comb begin
    any      = |nonempty;
    last_eff = (state == WB) ? grant : last;
    pick     = (&nonempty) ? ~last_eff : nonempty[1];
    state_nx = state;
    case (state)
      IDLE:    if (any) state_nx = FETCH;
      FETCH:   state_nx = CALC;
      CALC:    state_nx = WB;
      WB:      state_nx = any ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sum     = SW'(x) + SW'(h0) + SW'(h1) + SW'(h2);
    acc_nx  = acc - (acc >> DC_SHIFT) + ({lpf, 9'b0} >> DC_SHIFT);
    lpf_eff = lpf;
    h1_nx   = h0;
    h2_nx   = h1;
`ifdef PPG_SEED_DC_EN
    if (!seeded[grant]) begin
      acc_nx  = {x, 9'b0};
      lpf_eff = x;
      h1_nx   = x;
      h2_nx   = x;
    end
`endif
    dc_nx = acc_nx[AW-1:9];
    ac_nx = {1'b0, lpf_eff} - {1'b0, dc_nx};
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (accept[c]) mem[c][wr_ptr[c]] <= din[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      bus.o_ovf_red <= 1'b0;
      bus.o_ovf_ir  <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (accept[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])    rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (accept[c] && !pop[c])      count[c] <= count[c] + 1'b1;
        else if (pop[c] && !accept[c]) count[c] <= count[c] - 1'b1;
      end
      if (drop[0])            bus.o_ovf_red <= 1'b1;
      else if (bus.i_ovf_clr) bus.o_ovf_red <= 1'b0;
      if (drop[1])            bus.o_ovf_ir  <= 1'b1;
      else if (bus.i_ovf_clr) bus.o_ovf_ir  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      if ((state == IDLE || state == WB) && any) grant <= pick;
      if (state == WB) last <= grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      h0  <= '0;
      h1  <= '0;
      h2  <= '0;
      acc <= '0;
      lpf <= '0;
      for (int c = 0; c < 2; c++) begin
        h0_bank[c]  <= '0;
        h1_bank[c]  <= '0;
        h2_bank[c]  <= '0;
        acc_bank[c] <= '0;
      end
`ifdef PPG_SEED_DC_EN
      seeded <= '0;
`endif
      bus.o_valid <= 1'b0;
      bus.o_chan  <= 1'b0;
      bus.o_ac    <= '0;
      bus.o_dc    <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      case (state)
        FETCH: begin
          x   <= mem[grant][rd_ptr[grant]];
          h0  <= h0_bank[grant];
          h1  <= h1_bank[grant];
          h2  <= h2_bank[grant];
          acc <= acc_bank[grant];
        end
        CALC: lpf <= DATA_WIDTH'(sum >> 2);
        WB: begin
          h0_bank[grant]  <= x;
          h1_bank[grant]  <= h1_nx;
          h2_bank[grant]  <= h2_nx;
          acc_bank[grant] <= acc_nx;
`ifdef PPG_SEED_DC_EN
          seeded[grant]   <= 1'b1;
`endif
          bus.o_valid <= 1'b1;
          bus.o_chan  <= grant;
          bus.o_ac    <= ac_nx;
          bus.o_dc    <= dc_nx;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy = (state != IDLE) || (|nonempty);
endmodule

// File: tb/tb_ppg_dual_filter_sched.sv
// Bench for ppg_dual_filter_sched: directed vector table, corner sequences and
// randomized traffic scored against a per-channel arithmetic model.
module tb_ppg_dual_filter_sched;
  localparam int DW = 18;
  localparam int FD = 4;
  localparam int DS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ppg_dual_filter_sched_if #(.DATA_WIDTH(DW)) bus ();
  ppg_dual_filter_sched #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DC_SHIFT(DS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { int dc; int ac; } res_t;
  typedef struct { bit chan; int data; int dc; int ac; } vec_t;

  res_t   q_red[$];
  res_t   q_ir[$];
  longint m_hist [2][3];
  longint m_acc [2];
  bit     m_seeded [2];
  bit     mon_en  = 1'b0;
  int     mon_cnt = 0;
  vec_t   vecs [5];
  int     vt[$];
  int     vc[$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) m_hist[c][k] = 0;
      m_acc[c]    = 0;
      m_seeded[c] = 1'b0;
    end
    q_red.delete();
    q_ir.delete();
  endfunction

  // DC is an exponential average of lpf*512 with weight 1/2^DS, integer truncated.
  function automatic void model_push(input int c, input longint x);
    longint lpf, dc;
    res_t r;
`ifdef PPG_SEED_DC_EN
    if (!m_seeded[c]) begin
      m_seeded[c] = 1'b1;
      for (int k = 0; k < 3; k++) m_hist[c][k] = x;
      m_acc[c] = x * 512;
      r.dc = int'(x);
      r.ac = 0;
      if (c == 0) q_red.push_back(r); else q_ir.push_back(r);
      return;
    end
`endif
    lpf = (x + m_hist[c][0] + m_hist[c][1] + m_hist[c][2]) / 4;
    m_acc[c] = m_acc[c] - m_acc[c] / (1 << DS) + (lpf * 512) / (1 << DS);
    m_hist[c][2] = m_hist[c][1];
    m_hist[c][1] = m_hist[c][0];
    m_hist[c][0] = x;
    dc   = m_acc[c] / 512;
    r.dc = int'(dc);
    r.ac = int'(lpf - dc);
    if (c == 0) q_red.push_back(r); else q_ir.push_back(r);
  endfunction

  always @(posedge clk) begin : monitor
    res_t r;
    #1;
    if (mon_en && bus.o_valid === 1'b1) begin
      mon_cnt++;
      if (bus.o_chan == 1'b0) begin
        check("red_result_expected", q_red.size() > 0, 1);
        if (q_red.size() > 0) begin
          r = q_red.pop_front();
          check("red_dc", bus.o_dc, r.dc);
          check("red_ac", $signed(bus.o_ac), r.ac);
        end
      end else begin
        check("ir_result_expected", q_ir.size() > 0, 1);
        if (q_ir.size() > 0) begin
          r = q_ir.pop_front();
          check("ir_dc", bus.o_dc, r.dc);
          check("ir_ac", $signed(bus.o_ac), r.ac);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.i_red_valid = 1'b0;
    bus.i_red_data  = '0;
    bus.i_ir_valid  = 1'b0;
    bus.i_ir_data   = '0;
    bus.i_ovf_clr   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic strobe(input bit c, input int x);
    if (c) begin bus.i_ir_valid = 1'b1; bus.i_ir_data = DW'(x); end
    else begin bus.i_red_valid = 1'b1; bus.i_red_data = DW'(x); end
  endtask

  task automatic send(input bit c, input int x, input int edc, input int eac, input string tag);
    int k;
    @(negedge clk);
    strobe(c, x);
    @(posedge clk);
    @(negedge clk);
    bus.i_red_valid = 1'b0;
    bus.i_ir_valid  = 1'b0;
    k = 0;
    for (int n = 1; n <= 8 && k == 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) k = n;
    end
    check({tag, "_latency"}, k, 4);
    check({tag, "_chan"}, bus.o_chan, c);
    check({tag, "_dc"}, bus.o_dc, edc);
    check({tag, "_ac"}, $signed(bus.o_ac), eac);
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_red.size() != 0 || q_ir.size() != 0 || bus.o_busy === 1'b1) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_red_queue", q_red.size(), 0);
    check("drain_ir_queue", q_ir.size(), 0);
  endtask

  task automatic drive_rand(input bit c, input int n);
    int x;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(6, 12)) @(negedge clk);
      x = int'($urandom_range(0, (1 << DW) - 1));
      model_push(c, x);
      strobe(c, x);
      @(negedge clk);
      if (c) bus.i_ir_valid = 1'b0; else bus.i_red_valid = 1'b0;
    end
  endtask

  initial begin
    int k1, k2, c1, c2, d1, d2, a1, a2, nv;
    int sdc_r, sac_r, sdc_i, sac_i, rdc2, rac2;
`ifdef PPG_SEED_DC_EN
    vecs[0] = '{1'b0, 1000, 1000, 0};
    vecs[1] = '{1'b0, 1000, 1000, 0};
    vecs[2] = '{1'b1, 300, 300, 0};
    vecs[3] = '{1'b1, 700, 303, 97};
    vecs[4] = '{1'b0, 0, 992, -242};
    sdc_r = 300; sac_r = 0; sdc_i = 700; sac_i = 0; rdc2 = 300; rac2 = 0;
`else
    vecs[0] = '{1'b0, 1000, 7, 243};
    vecs[1] = '{1'b0, 1000, 23, 477};
    vecs[2] = '{1'b1, 300, 2, 73};
    vecs[3] = '{1'b1, 700, 10, 240};
    vecs[4] = '{1'b0, 0, 38, 462};
    sdc_r = 2; sac_r = 73; sdc_i = 5; sac_i = 170; rdc2 = 6; rac2 = 144;
`endif
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_chan", bus.o_chan, 0);
    check("rst_ac", bus.o_ac, 0);
    check("rst_dc", bus.o_dc, 0);
    check("rst_ovf_red", bus.o_ovf_red, 0);
    check("rst_ovf_ir", bus.o_ovf_ir, 0);
    check("rst_busy", bus.o_busy, 0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 5; i++)
      send(vecs[i].chan, vecs[i].data, vecs[i].dc, vecs[i].ac, $sformatf("vec%0d", i));

    // Same-edge RED/IR: RED wins the first tie, IR follows one slot later.
    do_reset();
    @(negedge clk);
    strobe(1'b0, 300);
    strobe(1'b1, 700);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    k1 = 0; k2 = 0; c1 = 0; c2 = 0; d1 = 0; d2 = 0; a1 = 0; a2 = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        if (k1 == 0) begin
          k1 = n; c1 = int'(bus.o_chan); d1 = int'(bus.o_dc); a1 = int'($signed(bus.o_ac));
        end else if (k2 == 0) begin
          k2 = n; c2 = int'(bus.o_chan); d2 = int'(bus.o_dc); a2 = int'($signed(bus.o_ac));
        end
      end
    end
    check("tie_first_latency", k1, 4);
    check("tie_first_chan", c1, 0);
    check("tie_first_dc", d1, sdc_r);
    check("tie_first_ac", a1, sac_r);
    check("tie_second_latency", k2, 7);
    check("tie_second_chan", c2, 1);
    check("tie_second_dc", d2, sdc_i);
    check("tie_second_ac", a2, sac_i);
    send(1'b0, 300, rdc2, rac2, "red_after_ir");

    // Overflow: RED strobed every clock; samples 1-6 and 9 fit.
    do_reset();
    mon_en = 1'b1;
    mon_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      strobe(1'b0, 100 * i + 7);
      if (i <= 6 || i == 9) model_push(0, 100 * i + 7);
      @(posedge clk);
      #2;
      if (i == 6) check("ovf_before_drop", bus.o_ovf_red, 0);
      if (i == 7) check("ovf_on_first_drop", bus.o_ovf_red, 1);
    end
    @(negedge clk);
    bus.i_red_valid = 1'b0;
    drain(100);
    check("ovf_result_count", mon_cnt, 7);
    check("ovf_red_sticky", bus.o_ovf_red, 1);
    check("ovf_ir_clean", bus.o_ovf_ir, 0);
    @(negedge clk);
    bus.i_ovf_clr = 1'b1;
    @(negedge clk);
    bus.i_ovf_clr = 1'b0;
    check("ovf_cleared", bus.o_ovf_red, 0);
    mon_en = 1'b0;

    // Reset while a sample is in CALC.
    do_reset();
    send(1'b0, 1000, vecs[0].dc, vecs[0].ac, "pre_rst");
    @(negedge clk);
    strobe(1'b0, 1000);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_dc", bus.o_dc, 0);
    check("midrst_ac", bus.o_ac, 0);
    check("midrst_chan", bus.o_chan, 0);
    check("midrst_busy", bus.o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    nv = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) nv++;
    end
    check("midrst_no_result", nv, 0);
    send(1'b0, 1000, vecs[0].dc, vecs[0].ac, "post_rst");

    // Alternating RED/IR every 3 clocks keeps the datapath saturated.
    do_reset();
    mon_en = 1'b1;
    vt.delete();
    vc.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      bus.i_red_valid = 1'b0;
      bus.i_ir_valid  = 1'b0;
      if (cyc % 3 == 0 && cyc < 36) begin
        int x;
        x = int'($urandom_range(0, (1 << DW) - 1));
        model_push((cyc / 3) % 2, x);
        strobe(1'((cyc / 3) % 2), x);
      end
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) begin
        vt.push_back(cyc);
        vc.push_back(int'(bus.o_chan));
      end
    end
    check("alt_result_count", vt.size(), 12);
    for (int i = 0; i < vt.size(); i++) begin
      check($sformatf("alt_chan%0d", i), vc[i], i % 2);
      if (i > 0) check($sformatf("alt_gap%0d", i), vt[i] - vt[i-1], 3);
    end
    check("alt_ovf_red", bus.o_ovf_red, 0);
    check("alt_ovf_ir", bus.o_ovf_ir, 0);
    drain(50);

    // Random traffic on both channels, each at most one sample per 7 clocks.
    do_reset();
    mon_en = 1'b1;
    mon_cnt = 0;
    fork
      drive_rand(1'b0, 30);
      drive_rand(1'b1, 30);
    join
    drain(300);
    check("rand_result_count", mon_cnt, 60);
    check("rand_ovf_red", bus.o_ovf_red, 0);
    check("rand_ovf_ir", bus.o_ovf_ir, 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
